hp_port_arbiter: RTL and testbench
==================================

HP_PORT_ARBITER -- requirements
Module: hp_port_arbiter

Interface
REQ-001 Parameter CACHE, default 4'b0011, value driven on awcache/arcache.
REQ-002 Parameter PROT, default 3'b000, value driven on awprot/arprot.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset_n  in  1  reset; asynchronous assert, active-low.
REQ-005 req_valid  in  2  per-requester transaction request; bit i = requester i.
REQ-006 req_write  in  2  per-requester direction: 1 = write, 0 = read.
REQ-007 req_addr  in  64  requester i address in bits [32i+31:32i].
REQ-008 req_wdata  in  64  requester i write data in bits [32i+31:32i].
REQ-009 req_ready  out  2  one-hot grant; request i is accepted in a cycle where req_valid[i] && req_ready[i].
REQ-010 rsp_valid  out  2  one-cycle completion pulse to requester i.
REQ-011 rsp_rdata  out  32  read data for the completing requester; 0 on writes.
REQ-012 rsp_resp  out  2  bresp/rresp of the completing transaction.
REQ-013 busy  out  1  high when state is not IDLE.
REQ-014 id_err  out  1  sticky; set on a response with a mismatched ID or rlast=0.
REQ-015 AXI3 master ports: awvalid/awready, awaddr[31:0], awid[5:0], wvalid/wready, wdata[31:0], wid[5:0], wlast, wstrb[3:0], bvalid/bready, bresp[1:0], bid[5:0], arvalid/arready, araddr[31:0], arid[5:0], rvalid/rready, rdata[31:0], rresp[1:0], rid[5:0], rlast, plus the constant ports listed under REQ-020.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; exactly one transaction is outstanding at a time.
REQ-017 In IDLE, the arbiter grants combinationally among asserted req_valid bits using round-robin.
  - Single request: that requester is granted.
  - Both requesting: the requester not granted last is granted.
  - last_grant resets to 1, so requester 0 wins the first contention.
REQ-018 On acceptance:
  - Capture write, {addr[31:2], 2'b00}, wdata and grant index.
  - Update last_grant.
  - Enter ISSUE on the next cycle.
REQ-019 req_ready is 0 in every state other than IDLE.
REQ-020 Constant outputs:
  - awlen = arlen = 0; awsize = arsize = 3'b010; awburst = arburst = 2'b01.
  - awlock = arlock = 0; awqos = arqos = 0.
  - wstrb = 4'hF; wlast = wvalid.
  - awid = wid = arid = {5'b0, grant index}.
REQ-021 ISSUE, write:
  - awvalid and wvalid assert in the first ISSUE cycle.
  - Each deasserts independently after its own handshake; handshakes may occur in any order or the same cycle.
  - Enter RESP the cycle after both handshakes have completed.
REQ-022 ISSUE, read: arvalid asserts in the first ISSUE cycle, holds until arready, then enter RESP.
REQ-023 Once asserted, a valid signal and its payload stay stable until that channel's handshake completes.
REQ-024 bready/rready are 1 only in RESP, and only for the matching direction.
REQ-025 On the b or r handshake at cycle N:
  - rsp_valid[grant] = 1 at cycle N+1, with rsp_resp and rsp_rdata registered.
  - State is IDLE at N+1, so a new grant may occur at N+1.
REQ-026 Minimum accept-to-accept period: 4 cycles, when all AXI ready/valid signals respond immediately.
REQ-027 A response with bid/rid != issued ID, or with rlast=0, sets id_err but still completes normally.
REQ-028 bvalid/rvalid seen outside RESP is ignored and never acknowledged.

Reset
REQ-029 While reset_n = 0:
  - State = IDLE; all AXI valid/ready outputs = 0; req_ready = 0.
  - rsp_valid = 0; busy = 0; id_err = 0; last_grant = 1.
  - Captured address/data registers = 0.
REQ-030 Reset mid-transaction aborts it immediately with no rsp_valid pulse; after release the block starts in IDLE.

Verification
REQ-031 Single write: req 0, addr 0x1000_0003, data 0xDEADBEEF, all readies high.
  - awaddr = 0x1000_0000, awid = 0, wdata = 0xDEADBEEF.
  - bresp = 0 -> rsp_valid = 2'b01, rsp_resp = 0.
REQ-032 Contention: both requesters issue reads continuously.
  - Grants alternate 0, 1, 0, 1.
  - arid matches the granted index and each rdata is routed to the correct rsp_valid bit.
REQ-033 Split handshake: wready held 0 for 3 cycles after awready.
  - awvalid drops after its handshake while wvalid holds.
  - RESP is entered only after the w handshake; busy stays 1 throughout.
REQ-034 Bad ID: respond with rid = 1 to a requester-0 read.
  - id_err = 1 and rsp_valid[0] pulses.
  - id_err stays 1 until reset.
REQ-035 Reset during RESP: deassert reset_n while bready = 1.
  - All outputs return to reset values asynchronously with no rsp_valid pulse.
  - A following read completes normally.
REQ-036 Stray response: bvalid held high in IDLE -> bready stays 0 and no rsp_valid pulse occurs.

Source files
------------

// File: rtl/hp_port_arbiter_if.sv
// AXI3 master-side bus bundle used by hp_port_arbiter; the master modport is
// the arbiter's view, the slave modport is the memory/interconnect view.
interface hp_port_arbiter_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [5:0]  awid;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic [3:0]  awqos;

   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [5:0]  wid;
   logic        wlast;
   logic [3:0]  wstrb;

   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [5:0]  bid;

   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [5:0]  arid;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic [3:0]  arqos;

   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [5:0]  rid;
   logic        rlast;

   modport master (
      output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
      input  awready,
      output wvalid, wdata, wid, wlast, wstrb,
      input  wready,
      input  bvalid, bresp, bid,
      output bready,
      output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
      input  arready,
      input  rvalid, rdata, rresp, rid, rlast,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
      output awready,
      input  wvalid, wdata, wid, wlast, wstrb,
      output wready,
      output bvalid, bresp, bid,
      input  bready,
      input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
      output arready,
      output rvalid, rdata, rresp, rid, rlast,
      input  rready
   );
endinterface

// File: rtl/hp_port_arbiter.sv
// Two-requester round-robin arbiter onto a single-beat AXI3 master port,
// one transaction outstanding at a time (IDLE -> ISSUE -> RESP).
module hp_port_arbiter #(
   parameter logic [3:0] CACHE = 4'b0011,
   parameter logic [2:0] PROT  = 3'b000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic [1:0]  req_ready,
   output logic [1:0]  rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        busy,
   output logic        id_err,
   hp_port_arbiter_if.master axi
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        idx_q, idx_d;
   logic        last_grant_q, last_grant_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        arvalid_q, arvalid_d;
   logic [1:0]  rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]  rsp_resp_q, rsp_resp_d;
   logic        id_err_q, id_err_d;

   logic        grant_idx;
   logic        accept;
   logic        sel_write;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [5:0]  issued_id;
   logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic        rsp_mismatch;

   // Under contention the requester that did not win last time goes first.
   always_comb begin
      grant_idx = 1'b0;
      case (req_valid)
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_grant_q;
         default: grant_idx = 1'b0;
      endcase
      req_ready = 2'b00;
      if ((state_q == IDLE) && reset_n && (req_valid != 2'b00))
         req_ready = grant_idx ? 2'b10 : 2'b01;
   end

   assign accept    = |(req_valid & req_ready);
   assign sel_write = req_write[grant_idx];
   assign sel_addr  = grant_idx ? req_addr[63:32]  : req_addr[31:0];
   assign sel_wdata = grant_idx ? req_wdata[63:32] : req_wdata[31:0];
   assign issued_id = {5'b0, idx_q};

   assign aw_hs = awvalid_q && axi.awready;
   assign w_hs  = wvalid_q  && axi.wready;
   assign ar_hs = arvalid_q && axi.arready;
   assign b_hs  = (state_q == RESP) &&  write_q && axi.bvalid;
   assign r_hs  = (state_q == RESP) && !write_q && axi.rvalid;

   assign rsp_mismatch = write_q ? (axi.bid != issued_id)
                                 : ((axi.rid != issued_id) || !axi.rlast);

   // ISSUE leaves only once every channel valid has already dropped, which
   // gives one settling cycle after the final address/data handshake.
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      idx_d        = idx_q;
      last_grant_d = last_grant_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      arvalid_d    = arvalid_q;
      rsp_valid_d  = 2'b00;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_resp_d   = rsp_resp_q;
      id_err_d     = id_err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d      = ISSUE;
               write_d      = sel_write;
               addr_d       = sel_addr & 32'hFFFF_FFFC;
               wdata_d      = sel_wdata;
               idx_d        = grant_idx;
               last_grant_d = grant_idx;
               awvalid_d    = sel_write;
               wvalid_d     = sel_write;
               arvalid_d    = !sel_write;
            end
         end
         ISSUE: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (ar_hs) arvalid_d = 1'b0;
            if (!awvalid_q && !wvalid_q && !arvalid_q)
               state_d = RESP;
         end
         RESP: begin
            if (b_hs || r_hs) begin
               state_d     = IDLE;
               rsp_valid_d = idx_q ? 2'b10 : 2'b01;
               rsp_resp_d  = write_q ? axi.bresp : axi.rresp;
               rsp_rdata_d = write_q ? 32'h0 : axi.rdata;
               if (rsp_mismatch)
                  id_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         idx_q        <= 1'b0;
         last_grant_q <= 1'b1;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rsp_valid_q  <= 2'b00;
         rsp_rdata_q  <= 32'h0;
         rsp_resp_q   <= 2'b00;
         id_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         idx_q        <= idx_d;
         last_grant_q <= last_grant_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         arvalid_q    <= arvalid_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_resp_q   <= rsp_resp_d;
         id_err_q     <= id_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign busy      = (state_q != IDLE);
   assign id_err    = id_err_q;

   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = addr_q;
   assign axi.awid    = issued_id;
   assign axi.awlen   = 4'd0;
   assign axi.awsize  = 3'b010;
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = CACHE;
   assign axi.awprot  = PROT;
   assign axi.awqos   = 4'd0;

   assign axi.wvalid  = wvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wid     = issued_id;
   assign axi.wlast   = wvalid_q;
   assign axi.wstrb   = 4'hF;

   assign axi.bready  = (state_q == RESP) && write_q;

   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = addr_q;
   assign axi.arid    = issued_id;
   assign axi.arlen   = 4'd0;
   assign axi.arsize  = 3'b010;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = CACHE;
   assign axi.arprot  = PROT;
   assign axi.arqos   = 4'd0;

   assign axi.rready  = (state_q == RESP) && !write_q;

endmodule

// File: tb/tb_hp_port_arbiter.sv
// Directed bench for hp_port_arbiter: the AXI slave side is driven by hand,
// with read data and IDs echoed from the issued ID unless overridden.
module tb_hp_port_arbiter;

   logic        clock;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        busy;
   logic        id_err;

   logic [31:0] rd_base;
   logic        rid_force_en;
   logic [5:0]  rid_force;

   int total_checks;
   int bad_checks;

   hp_port_arbiter_if bus ();

   hp_port_arbiter dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .busy      (busy),
      .id_err    (id_err),
      .axi       (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Slave model: read data tagged by the ID on the bus so routing is visible.
   always_comb begin
      bus.rdata = rd_base ^ {26'b0, bus.arid};
      bus.rid   = rid_force_en ? rid_force : bus.arid;
      bus.bid   = bus.awid;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] write);
      req_valid = valid;
      req_write = write;
      #1;
   endtask

   task automatic setSlave(input logic awr, input logic wr, input logic arr,
                           input logic bv, input logic rv);
      bus.awready = awr;
      bus.wready  = wr;
      bus.arready = arr;
      bus.bvalid  = bv;
      bus.rvalid  = rv;
   endtask

   initial begin
      total_checks = 0;
      bad_checks   = 0;
      reset_n      = 1'b0;
      req_valid    = 2'b00;
      req_write    = 2'b00;
      req_addr     = 64'h0;
      req_wdata    = 64'h0;
      rd_base      = 32'h0;
      rid_force_en = 1'b0;
      rid_force    = 6'd0;
      bus.bresp    = 2'b00;
      bus.rresp    = 2'b00;
      bus.rlast    = 1'b1;
      setSlave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset values, with requests already pending.
      repeat (2) @(posedge clock);
      #1;
      applyStimulus(2'b11, 2'b00);
      checkOutput("rst_req_ready", {62'b0, req_ready}, 64'h0);
      checkOutput("rst_busy", {63'b0, busy}, 64'h0);
      checkOutput("rst_id_err", {63'b0, id_err}, 64'h0);
      checkOutput("rst_rsp_valid", {62'b0, rsp_valid}, 64'h0);
      checkOutput("rst_valids", {60'b0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready}, 64'h0);
      checkOutput("rst_rready", {63'b0, bus.rready}, 64'h0);
      checkOutput("rst_awaddr", {32'b0, bus.awaddr}, 64'h0);
      req_valid = 2'b00;
      reset_n   = 1'b1;
      nextCycle();

      // Single write from requester 0 with every ready high.
      req_addr  = {32'h0, 32'h1000_0003};
      req_wdata = {32'h0, 32'hDEAD_BEEF};
      setSlave(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b01, 2'b01);
      checkOutput("wr_req_ready", {62'b0, req_ready}, 64'h1);
      checkOutput("wr_consts", {44'b0, bus.awlen, bus.awsize, bus.awburst, bus.awcache, bus.awprot, bus.wstrb},
                  {44'b0, 4'd0, 3'b010, 2'b01, 4'b0011, 3'b000, 4'hF});
      nextCycle();
      req_valid = 2'b00;
      checkOutput("wr_issue_valids", {61'b0, bus.awvalid, bus.wvalid, bus.wlast}, 64'h7);
      checkOutput("wr_busy", {63'b0, busy}, 64'h1);
      checkOutput("wr_awaddr", {32'b0, bus.awaddr}, 64'h1000_0000);
      checkOutput("wr_awid", {58'b0, bus.awid}, 64'h0);
      checkOutput("wr_wdata", {32'b0, bus.wdata}, 64'hDEAD_BEEF);
      nextCycle();
      checkOutput("wr_valids_drop", {61'b0, bus.awvalid, bus.wvalid, bus.bready}, 64'h0);
      bus.bvalid = 1'b1;
      bus.bresp  = 2'b00;
      nextCycle();
      checkOutput("wr_bready", {63'b0, bus.bready}, 64'h1);
      nextCycle();
      checkOutput("wr_rsp_valid", {62'b0, rsp_valid}, 64'h1);
      checkOutput("wr_rsp_resp", {62'b0, rsp_resp}, 64'h0);
      checkOutput("wr_rsp_rdata", {32'b0, rsp_rdata}, 64'h0);
      checkOutput("wr_idle", {63'b0, busy}, 64'h0);
      bus.bvalid = 1'b0;
      nextCycle();
      checkOutput("wr_rsp_pulse", {62'b0, rsp_valid}, 64'h0);

      // Fresh reset so the first contention starts from last_grant = 1.
      reset_n = 1'b0;
      nextCycle();
      reset_n = 1'b1;
      nextCycle();

      // Continuous contention between two readers, 4-cycle turnaround.
      req_addr = {32'h2000_0105, 32'h1000_0106};
      rd_base  = 32'h5A5A_0000;
      setSlave(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(2'b11, 2'b00);
      for (int k = 0; k < 4; k++) begin
         logic g;
         g = k[0];
         checkOutput($sformatf("rr_grant%0d", k), {62'b0, req_ready}, g ? 64'h2 : 64'h1);
         nextCycle();
         checkOutput($sformatf("rr_arvalid%0d", k), {63'b0, bus.arvalid}, 64'h1);
         checkOutput($sformatf("rr_arid%0d", k), {58'b0, bus.arid}, {63'b0, g});
         checkOutput($sformatf("rr_araddr%0d", k), {32'b0, bus.araddr},
                     g ? 64'h2000_0104 : 64'h1000_0104);
         nextCycle();
         nextCycle();
         checkOutput($sformatf("rr_rready%0d", k), {63'b0, bus.rready}, 64'h1);
         nextCycle();
         checkOutput($sformatf("rr_rsp_valid%0d", k), {62'b0, rsp_valid}, g ? 64'h2 : 64'h1);
         checkOutput($sformatf("rr_rdata%0d", k), {32'b0, rsp_rdata},
                     {32'b0, 32'h5A5A_0000 ^ {31'b0, g}});
      end
      applyStimulus(2'b00, 2'b00);

      // Requester 1 write with wready held low for three cycles after awready.
      req_addr  = {32'h3000_0008, 32'h0};
      req_wdata = {32'h1234_5678, 32'h0};
      setSlave(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(2'b10, 2'b10);
      checkOutput("sp_req_ready", {62'b0, req_ready}, 64'h2);
      nextCycle();
      req_valid = 2'b00;
      checkOutput("sp_issue", {61'b0, bus.awvalid, bus.wvalid, busy}, 64'h7);
      checkOutput("sp_ids", {52'b0, bus.awid, bus.wid}, {52'b0, 6'd1, 6'd1});
      for (int c = 0; c < 3; c++) begin
         nextCycle();
         checkOutput($sformatf("sp_hold%0d", c), {60'b0, bus.awvalid, bus.wvalid, busy, bus.bready}, 64'h6);
         checkOutput($sformatf("sp_wdata%0d", c), {32'b0, bus.wdata}, 64'h1234_5678);
      end
      nextCycle();
      bus.wready = 1'b1;
      checkOutput("sp_w_last_wait", {61'b0, bus.wvalid, busy, bus.bready}, 64'h6);
      nextCycle();
      checkOutput("sp_drain", {61'b0, bus.wvalid, busy, bus.bready}, 64'h2);
      bus.bvalid = 1'b1;
      bus.bresp  = 2'b10;
      nextCycle();
      checkOutput("sp_bready", {62'b0, busy, bus.bready}, 64'h3);
      nextCycle();
      checkOutput("sp_rsp_valid", {62'b0, rsp_valid}, 64'h2);
      checkOutput("sp_rsp_resp", {62'b0, rsp_resp}, 64'h2);
      bus.bvalid = 1'b0;
      bus.bresp  = 2'b00;

      // Requester 0 read answered with the wrong ID.
      req_addr     = {32'h0, 32'h0000_0040};
      rd_base      = 32'h0BAD_0000;
      rid_force_en = 1'b1;
      rid_force    = 6'd1;
      setSlave(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(2'b01, 2'b00);
      checkOutput("id_pre", {63'b0, id_err}, 64'h0);
      nextCycle();
      req_valid = 2'b00;
      repeat (3) nextCycle();
      checkOutput("id_rsp_valid", {62'b0, rsp_valid}, 64'h1);
      checkOutput("id_rsp_rdata", {32'b0, rsp_rdata}, 64'h0BAD_0000);
      checkOutput("id_err_set", {63'b0, id_err}, 64'h1);
      rid_force_en = 1'b0;
      repeat (3) nextCycle();
      checkOutput("id_err_sticky", {63'b0, id_err}, 64'h1);

      // Reset asserted while bready is high, then a clean read.
      req_addr  = {32'h0, 32'h4000_0000};
      req_wdata = {32'h0, 32'h0000_1111};
      setSlave(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b01, 2'b01);
      nextCycle();
      req_valid = 2'b00;
      nextCycle();
      nextCycle();
      checkOutput("rr_mid_bready", {62'b0, busy, bus.bready}, 64'h3);
      reset_n    = 1'b0;
      bus.bvalid = 1'b1;
      #1;
      checkOutput("ar_outputs", {59'b0, bus.bready, busy, id_err, rsp_valid}, 64'h0);
      checkOutput("ar_awaddr", {32'b0, bus.awaddr}, 64'h0);
      nextCycle();
      checkOutput("ar_no_pulse", {62'b0, rsp_valid}, 64'h0);
      reset_n  = 1'b1;
      rd_base  = 32'h7777_0000;
      req_addr = {32'h0000_0080, 32'h0};
      setSlave(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(2'b10, 2'b00);
      checkOutput("ar_req_ready", {62'b0, req_ready}, 64'h2);
      nextCycle();
      req_valid = 2'b00;
      repeat (3) nextCycle();
      checkOutput("ar_rsp_valid", {62'b0, rsp_valid}, 64'h2);
      checkOutput("ar_rsp_rdata", {32'b0, rsp_rdata}, 64'h7777_0001);
      checkOutput("ar_id_err", {63'b0, id_err}, 64'h0);

      // Stray responses while idle.
      setSlave(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         nextCycle();
         checkOutput($sformatf("stray%0d", c), {59'b0, bus.bready, bus.rready, busy, rsp_valid}, 64'h0);
      end

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
